// File: rtl/st_irq_ctrl.sv
// Interrupt controller for the 68000 bus: latches HBL/VBL, drives prioritised IPL lines and
// routes interrupt-acknowledge cycles to the MFP (vectored), autovector (VPA) or bus error.
module st_irq_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       hbl_pulse,
  input  logic       vbl_pulse,
  input  logic       mfp_irq,
  input  logic       mfp_dtack,
  input  logic [2:0] cpu_fc,
  input  logic       cpu_as_n,
  input  logic [2:0] cpu_addr,
  output logic [2:0] cpu_ipl_n,
  output logic       mfp_iack,
  output logic       vpa,
  output logic       berr,
  output logic       iack_busy
);

  typedef enum logic [2:0] {StIdle, StAckMfp, StAckAuto, StAckSpur, StWaitEnd} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hbl_pend_q, hbl_pend_d;
  logic       vbl_pend_q, vbl_pend_d;
  logic [2:0] ipl_n_q, ipl_n_d;
  logic       mfp_iack_q, mfp_iack_d;
  logic       vpa_q, vpa_d;
  logic       berr_q, berr_d;
  logic       iack_cyc;
  logic       clr_hbl, clr_vbl;
  logic [2:0] level;

  assign iack_cyc = (cpu_fc == 3'b111) && !cpu_as_n;
  assign level    = mfp_irq ? 3'd6 : vbl_pend_q ? 3'd4 : hbl_pend_q ? 3'd2 : 3'd0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hbl_pend_d = hbl_pend_q;
    vbl_pend_d = vbl_pend_q;
    ipl_n_d    = ipl_n_q;
    mfp_iack_d = mfp_iack_q;
    vpa_d      = vpa_q;
    berr_d     = berr_q;
    clr_hbl    = 1'b0;
    clr_vbl    = 1'b0;
    if (clk_en) begin
      ipl_n_d = ~level;
      unique case (state_q)
        StIdle: begin
          if (iack_cyc) begin
            if (cpu_addr == 3'd6) begin
              state_d    = StAckMfp;
              mfp_iack_d = 1'b1;
              cnt_d      = 8'd0;
            end else if (cpu_addr == 3'd2 || cpu_addr == 3'd4) begin
              state_d = StAckAuto;
              vpa_d   = 1'b1;
              clr_hbl = (cpu_addr == 3'd2);
              clr_vbl = (cpu_addr == 3'd4);
            end else begin
              state_d = StAckSpur;
              berr_d  = 1'b1;
            end
          end
        end
        StAckMfp: begin
          // Strobe release wins over a same-cycle dtack: the CPU has already left the cycle.
          if (cpu_as_n) begin
            state_d    = StIdle;
            mfp_iack_d = 1'b0;
            vpa_d      = 1'b0;
            berr_d     = 1'b0;
          end else if (mfp_dtack) begin
            state_d = StWaitEnd;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            state_d = StWaitEnd;
            berr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StAckAuto, StAckSpur, StWaitEnd: begin
          if (cpu_as_n) begin
            state_d    = StIdle;
            mfp_iack_d = 1'b0;
            vpa_d      = 1'b0;
            berr_d     = 1'b0;
          end
        end
        default: begin
          state_d    = StIdle;
          mfp_iack_d = 1'b0;
          vpa_d      = 1'b0;
          berr_d     = 1'b0;
        end
      endcase
      // A new event in the acknowledge cycle keeps the level pending.
      hbl_pend_d = hbl_pulse | (hbl_pend_q & ~clr_hbl);
      vbl_pend_d = vbl_pulse | (vbl_pend_q & ~clr_vbl);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      hbl_pend_q <= 1'b0;
      vbl_pend_q <= 1'b0;
      ipl_n_q    <= 3'b111;
      mfp_iack_q <= 1'b0;
      vpa_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hbl_pend_q <= hbl_pend_d;
      vbl_pend_q <= vbl_pend_d;
      ipl_n_q    <= ipl_n_d;
      mfp_iack_q <= mfp_iack_d;
      vpa_q      <= vpa_d;
      berr_q     <= berr_d;
    end
  end

  assign cpu_ipl_n = ipl_n_q;
  assign mfp_iack  = mfp_iack_q;
  assign vpa       = vpa_q;
  assign berr      = berr_q;
  assign iack_busy = (state_q != StIdle);

endmodule
